// File: rtl/pong_pkg.sv
// Shared Pong definitions: controller state encodings, score width and
// screen/paddle geometry used by both the sequencer and the datapath.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int SCORE_W       = 4;
    localparam int SCREEN_WIDTH  = 480;
    localparam int SCREEN_HEIGHT = 272;
    localparam int PADDLE_WIDTH  = 8;
    localparam int PADDLE_HEIGHT = 48;
    localparam int PADDLE_MARGIN = 16;

endpackage

// File: rtl/pong_game_ctrl_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a registered
// single-cycle rising-edge pulse.
module sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: frame tick from vsync, game FSM, step strobes
// for the ball/paddle datapath and score keeping.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE          = 9,
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int POINT_DELAY_FRAMES = 90,
    parameter int BALL_DIV           = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               vsync,
    input  logic               btn_start,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               ball_step,
    output logic               paddle_step,
    output logic               serve,
    output logic               serve_dir,
    output logic               ball_visible,
    output logic               game_over,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [2:0]         state
);

    localparam int MAX_DLY = (SERVE_DELAY_FRAMES > POINT_DELAY_FRAMES) ?
                             SERVE_DELAY_FRAMES : POINT_DELAY_FRAMES;
    localparam int CNT_W = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
    localparam int DIV_W = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;

    localparam logic [CNT_W-1:0]   SERVE_LD = CNT_W'(SERVE_DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LD = CNT_W'(POINT_DELAY_FRAMES - 1);
    localparam logic [DIV_W-1:0]   DIV_TOP  = DIV_W'(BALL_DIV - 1);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

    logic frame_tick, start_edge;

    sync_edge u_vs (
        .clk    (clk),
        .resetn (resetn),
        .din    (vsync),
        .rise   (frame_tick)
    );

    sync_edge u_start (
        .clk    (clk),
        .resetn (resetn),
        .din    (btn_start),
        .rise   (start_edge)
    );

    state_t             st, st_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [DIV_W-1:0]   div, div_n;
    logic [SCORE_W-1:0] s1_n, s2_n;
    logic               dir_n, ball_n, pad_n, serve_n;

    assign state = st;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st           <= ST_IDLE;
            cnt          <= '0;
            div          <= '0;
            score1       <= '0;
            score2       <= '0;
            serve_dir    <= 1'b1;
            ball_step    <= 1'b0;
            paddle_step  <= 1'b0;
            serve        <= 1'b0;
            ball_visible <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            st           <= st_n;
            cnt          <= cnt_n;
            div          <= div_n;
            score1       <= s1_n;
            score2       <= s2_n;
            serve_dir    <= dir_n;
            ball_step    <= ball_n;
            paddle_step  <= pad_n;
            serve        <= serve_n;
            ball_visible <= (st_n == ST_PLAY);
            game_over    <= (st_n == ST_OVER);
        end
    end

    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        div_n   = div;
        s1_n    = score1;
        s2_n    = score2;
        dir_n   = serve_dir;
        ball_n  = 1'b0;
        pad_n   = 1'b0;
        serve_n = 1'b0;

        unique case (st)
            ST_IDLE: begin
                pad_n = frame_tick;
            end
            ST_SERVE: begin
                pad_n = frame_tick;
                if (frame_tick) begin
                    if (cnt == '0) begin
                        serve_n = 1'b1;
                        st_n    = ST_PLAY;
                        div_n   = '0;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    pad_n = 1'b1;
                    if (div == DIV_TOP) begin
                        ball_n = 1'b1;
                        div_n  = '0;
                    end else begin
                        div_n = div + 1'b1;
                    end
                end
                if (miss_left || miss_right) begin
                    if (miss_right) s1_n = score1 + 1'b1;
                    if (miss_left)  s2_n = score2 + 1'b1;
                    if (miss_left ^ miss_right) dir_n = miss_right;
                    // A simultaneous double miss can end the game for either side.
                    if ((miss_right && s1_n == WIN) ||
                        (miss_left && s2_n == WIN)) begin
                        st_n = ST_OVER;
                    end else begin
                        st_n  = ST_POINT;
                        cnt_n = POINT_LD;
                    end
                end
            end
            ST_POINT: begin
                pad_n = frame_tick;
                if (frame_tick) begin
                    if (cnt == '0) begin
                        st_n  = ST_SERVE;
                        cnt_n = SERVE_LD;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            end
            ST_OVER: begin
            end
            default: begin
                st_n = ST_IDLE;
            end
        endcase

        // Start wins over any miss seen in the same cycle.
        if (start_edge) begin
            st_n  = ST_SERVE;
            cnt_n = SERVE_LD;
            s1_n  = '0;
            s2_n  = '0;
            dir_n = 1'b1;
        end
    end

endmodule
